// File: rtl/input_cond_pkg.sv
// Shared constants for the pushbutton/switch input conditioner.
// Channel indices name the three board pushbuttons; the debounce defaults
// cover both the short simulation value and the 20 ms board value.
package input_cond_pkg;

  // Pushbutton channel indices
  localparam int BTN_RESET = 0;
  localparam int BTN_RUN   = 1;
  localparam int BTN_CLRLD = 2;

  // Default geometry of the input bundle
  localparam int N_BTN_DEFAULT = 3;
  localparam int SW_W_DEFAULT  = 8;

  // Debounce length in clock cycles: short for simulation, 20 ms at 50 MHz on the board
  localparam int DEBOUNCE_CYCLES_SIM = 4;
  localparam int DEBOUNCE_CYCLES_HW  = 1_000_000;

  // Width of a counter able to hold 0 .. cycles
  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// debounce_channel: one pushbutton lane.
// Raw active-low button -> 2-flop synchronizer -> stability counter ->
// debounced active-high level plus a one-cycle press pulse.
// Optional macro INPUT_COND_RELEASE_PULSE_EN adds a one-cycle release pulse.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level,
  output logic press
`ifdef INPUT_COND_RELEASE_PULSE_EN
  ,
  output logic rel_pulse
`endif
);

  localparam int CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic             sample;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             level_reg;
  logic             level_next;
  logic             press_reg;
  logic             press_next;
  logic             mismatch;
  logic             accept;

  // Two-flop synchronizer; resets to "released" (raw high)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], btn_n};
    end
  end

  // Synchronized sample in active-high (pressed = 1) form
  assign sample   = ~sync_reg[1];
  assign mismatch = (sample != level_reg);
  assign accept   = mismatch && (cnt_reg == CNT_LAST);

  // Count consecutive differing samples; any agreeing sample restarts the count
  always_comb begin
    cnt_next   = '0;
    level_next = level_reg;
    press_next = 1'b0;
    if (mismatch) begin
      if (accept) begin
        cnt_next   = '0;
        level_next = sample;
        press_next = sample;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  // Counter, debounced level and press pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      press_reg <= press_next;
    end
  end

  assign level = level_reg;
  assign press = press_reg;

`ifdef INPUT_COND_RELEASE_PULSE_EN
  logic rel_reg;

  // Release pulse: the accepted transition back to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_reg <= 1'b0;
    end else begin
      rel_reg <= accept && !sample;
    end
  end

  assign rel_pulse = rel_reg;
`endif

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: front end of the shift-add multiplier.
// Synchronizes the slide switches and debounces the active-low pushbuttons,
// producing clean levels and one-cycle press pulses for the control FSM.
// Optional macro INPUT_COND_RELEASE_PULSE_EN adds the Btn_release output.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int N_BTN           = N_BTN_DEFAULT,
  parameter int SW_W            = SW_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] Btn_USH,
  input  logic [SW_W-1:0]  S_USH,
  output logic [SW_W-1:0]  S,
  output logic [N_BTN-1:0] Btn_level,
  output logic [N_BTN-1:0] Btn_press
`ifdef INPUT_COND_RELEASE_PULSE_EN
  ,
  output logic [N_BTN-1:0] Btn_release
`endif
);

  logic [SW_W-1:0] sw_meta_reg;
  logic [SW_W-1:0] sw_sync_reg;

  // Switch path: plain 2-flop synchronizer, switches are not debounced
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_meta_reg <= '0;
      sw_sync_reg <= '0;
    end else begin
      sw_meta_reg <= S_USH;
      sw_sync_reg <= sw_meta_reg;
    end
  end

  assign S = sw_sync_reg;

  // Button path: one independent debounce lane per pushbutton
  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
        .clk       (Clk),
        .rst_n     (Reset),
        .btn_n     (Btn_USH[gi]),
        .level     (Btn_level[gi]),
        .press     (Btn_press[gi])
`ifdef INPUT_COND_RELEASE_PULSE_EN
        ,
        .rel_pulse (Btn_release[gi])
`endif
      );
    end
  endgenerate

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream stage of the shift-add multiplier top level.
- Takes the raw, unsynchronized, active-low pushbuttons (Reset, Run, ClearA_LoadB) and the 8 slide switches.
- Delivers to the multiplier control FSM:
  - synchronized switch values;
  - debounced active-high button levels;
  - single-cycle press pulses.
- Removes metastability and contact bounce so the multiplier sees exactly one Run/Load event per physical press.

Parameters:
- N_BTN, 3: number of pushbutton channels. Index 0 = Reset, 1 = Run, 2 = ClearA_LoadB.
- SW_W, 8: switch bus width.
- DEBOUNCE_CYCLES, 4: consecutive stable samples required to accept a button change. Must be >= 1. Simulation default; board build overrides to 1_000_000 (20 ms at 50 MHz).

Ports:
- Clk, in, 1: system clock, 50 MHz.
- Reset, in, 1: asynchronous, active-low system reset.
- Btn_USH, in, N_BTN: raw pushbuttons, 0 = pressed, asynchronous to Clk.
- S_USH, in, SW_W: raw switches, asynchronous to Clk.
- S, out, SW_W: synchronized switches.
- Btn_level, out, N_BTN: debounced button state, 1 = pressed.
- Btn_press, out, N_BTN: one-cycle pulse on each accepted press.

Behaviour:
- Reset (Reset = 0) takes effect immediately, without waiting for Clk:
  - S = 0, Btn_level = 0, Btn_press = 0;
  - switch sync flops = 0;
  - button sync flops = 1 (released);
  - all debounce counters = 0.
- Switch path: 2-flop synchronizer per bit, no debounce. A change on S_USH before edge e0 appears on S after edge e1 (2-edge latency).
- Button path, per channel, independent of the others:
  - 2-flop synchronizer produces sample b = ~sync2 (active-high pressed).
  - Each edge with b != Btn_level: cnt increments.
    - When cnt == DEBOUNCE_CYCLES-1 (and b still differs): Btn_level <= b and cnt <= 0 on that edge.
  - Each edge with b == Btn_level: cnt <= 0. Any bounce restarts the count.
  - Counter width: $clog2(DEBOUNCE_CYCLES+1).
  - Latency: a raw change before edge e0 that stays stable updates Btn_level after edge e(DEBOUNCE_CYCLES+1), i.e. DEBOUNCE_CYCLES+2 edges.
  - Glitches shorter than DEBOUNCE_CYCLES synchronized samples never reach Btn_level.
- Btn_press:
  - Registered; high for exactly the one cycle in which Btn_level goes 0 -> 1.
  - Never asserted on release.
  - Holding a button produces no further pulses.
- Simultaneous changes on several channels are processed independently; pulses may coincide.
- Reset mid-count: counters clear and levels drop to 0 immediately. After reset is released, a still-held button needs the full DEBOUNCE_CYCLES again before it is accepted, and then generates a press pulse.
- With DEBOUNCE_CYCLES = 1, a change is accepted on the first mismatching synchronized sample.

Optional Feature:
- Macro: INPUT_COND_RELEASE_PULSE_EN.
- Defined: adds output port Btn_release (out, N_BTN). It pulses for one cycle when Btn_level goes 1 -> 0, with the same timing rules as Btn_press, and resets to 0.
- Undefined: port absent, and no release-detect logic is synthesized.

Decomposition:
- Package input_cond_pkg holds:
  - channel index constants BTN_RESET = 0, BTN_RUN = 1, BTN_CLRLD = 2;
  - default DEBOUNCE_CYCLES_SIM = 4 and DEBOUNCE_CYCLES_HW = 1_000_000.
- Sub-module debounce_channel: one synchronizer, counter, level register and edge pulse(s) for a single button. Instantiated N_BTN times via generate.
- The switch synchronizer stays inline in input_conditioner.

Test Plan (DEBOUNCE_CYCLES = 4, Btn_USH idle = 3'b111):
- Reset = 0 with S_USH = 8'hFF -> S, Btn_level, Btn_press all 0 asynchronously. After Reset = 1, idle buttons give no pulses for 20 cycles.
- S_USH = 8'hD6 (-42) applied before edge e0 -> S = 8'hD6 after edge e1. Then S_USH = 8'h02 -> S = 8'h02 two edges later.
- Btn_USH[1] held 0 for 20 cycles, then 1:
  - Btn_level[1] rises after edge e5;
  - Btn_press[1] high exactly that one cycle;
  - Btn_level[1] falls 6 edges after release;
  - no second pulse.
- Btn_USH[1] low for 3 cycles, then high -> Btn_level[1] and Btn_press[1] stay 0. A 5-cycle low pulse that bounces high for 1 cycle mid-way is also rejected.
- Btn_USH[0] and Btn_USH[2] pressed on the same edge -> Btn_press[0] and Btn_press[2] assert in the same cycle; Btn_press[1] stays 0.
- Btn_USH[2] held low; Reset pulsed low after 3 cycles, then released -> counter cleared, Btn_level[2] = 0 during reset. Btn_press[2] asserts 6 edges after reset release. With INPUT_COND_RELEASE_PULSE_EN defined, Btn_release[2] pulses once 6 edges after the button is released.
